// File: rtl/common.sv
// Shared types for the coherence bus arbiter: FSM states, request kinds, data-source codes.
// No logic, so no latency.
// No handshake, so no backpressure.
package common;

  typedef enum logic [2:0] {IDLE, SNOOP, INV, PEER, MEM, DONE} bus_state_t;

  typedef enum logic [1:0] {RT_RD, RT_WR, RT_INV} req_type_t;

  typedef logic [1:0] datasel_t;
  localparam datasel_t DS_NONE = 2'b00;
  localparam datasel_t DS_MEM  = 2'b01;
  localparam datasel_t DS_PEER = 2'b10;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: the first set request at or after rr_ptr, wrapping modulo NCPU.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to take the result.
module rr_picker #(
  parameter int NCPU = 4,
  parameter int PW   = (NCPU > 1) ? $clog2(NCPU) : 1
) (
  input  logic [NCPU-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NCPU-1:0] winner_oh,
  output logic [PW-1:0]   winner_idx,
  output logic            vld
);

  always_comb begin
    int c;
    c          = 0;
    winner_oh  = '0;
    winner_idx = '0;
    vld        = 1'b0;
    for (int off = 0; off < NCPU; off++) begin
      c = int'(rr_ptr) + off;
      if (c >= NCPU) c = c - NCPU;
      if (!vld && req[c]) begin
        vld          = 1'b1;
        winner_idx   = c[PW-1:0];
        winner_oh[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant, then snoop/invalidate/peer/memory phases per transaction.
// Latency: peer read 3 cycles to done, invalidate 2, memory paths finish one cycle after u_rdy.
// Backpressure: requests are sampled only in IDLE; MEM waits for u_rdy indefinitely.
module coherence_bus_arbiter #(
  parameter int NCPU    = 4,
  parameter int TAG_W   = 13,
  parameter int WORD_W  = 16,
  parameter int MADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCPU-1:0]          rd_miss,
  input  logic [NCPU-1:0]          wr_miss,
  input  logic [NCPU-1:0]          inv_req,
  input  logic [NCPU*TAG_W-1:0]    req_tag,
  input  logic [NCPU-1:0]          search_found,
  input  logic [NCPU*WORD_W-1:0]   snoop_data,
  input  logic                     u_rdy,
  output logic [NCPU-1:0]          grant,
  output logic [NCPU-1:0]          cpu_search,
  output logic [TAG_W-1:0]         bus_tag,
  output logic [NCPU-1:0]          invalidate_out,
  output logic [2*NCPU-1:0]        cpu_datasel,
  output logic [WORD_W-1:0]        peer_data,
  output logic                     u_re,
  output logic [MADDR_W-1:0]       u_addr,
  output logic [NCPU-1:0]          done
);
  import common::*;

  localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;

  bus_state_t      state_q, state_d;
  req_type_t       rtype_q, pick_type;
  logic [PW-1:0]   win_idx_q, rr_ptr_q, pick_idx, sup_idx;
  logic [NCPU-1:0] win_oh_q, pick_oh, req_any, found_q, found_m;
  logic            pick_vld;
  logic [TAG_W-1:0] bus_tag_q;

  assign req_any = rd_miss | wr_miss | inv_req;
  assign found_m = search_found & ~win_oh_q;

  rr_picker #(.NCPU(NCPU), .PW(PW)) u_picker (
    .req        (req_any),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .vld        (pick_vld)
  );

  // Only the strongest request kind of the winning core is served now.
  always_comb begin
    pick_type = RT_RD;
    if (inv_req[pick_idx])      pick_type = RT_INV;
    else if (wr_miss[pick_idx]) pick_type = RT_WR;
  end

  // Lowest-index responder among the snoop hits captured in SNOOP.
  always_comb begin
    sup_idx = '0;
    for (int i = NCPU - 1; i >= 0; i--) begin
      if (found_q[i]) sup_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rtype_q   <= RT_RD;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      bus_tag_q <= '0;
      found_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        rtype_q   <= pick_type;
        win_idx_q <= pick_idx;
        win_oh_q  <= pick_oh;
        bus_tag_q <= req_tag[int'(pick_idx)*TAG_W +: TAG_W];
      end
      if (state_q == SNOOP) found_q <= found_m;
      if (state_q == DONE) begin
        rr_ptr_q <= (win_idx_q == PW'(NCPU - 1)) ? '0 : win_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant          = '0;
    cpu_search     = '0;
    invalidate_out = '0;
    cpu_datasel    = {NCPU{DS_NONE}};
    peer_data      = '0;
    u_re           = 1'b0;
    done           = '0;
    if (state_q != IDLE) grant = win_oh_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) state_d = (pick_type == RT_INV) ? INV : SNOOP;
      end
      SNOOP: begin
        cpu_search = ~win_oh_q;
        if (rtype_q == RT_WR) state_d = INV;
        else if (|found_m)    state_d = PEER;
        else                  state_d = MEM;
      end
      INV: begin
        invalidate_out = ~win_oh_q;
        state_d = (rtype_q == RT_WR) ? MEM : DONE;
      end
      PEER: begin
        cpu_datasel[int'(win_idx_q)*2 +: 2] = DS_PEER;
        peer_data = snoop_data[int'(sup_idx)*WORD_W +: WORD_W];
        state_d   = DONE;
      end
      MEM: begin
        u_re = 1'b1;
        if (u_rdy) begin
          cpu_datasel[int'(win_idx_q)*2 +: 2] = DS_MEM;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = win_oh_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_tag = bus_tag_q;
  assign u_addr  = bus_tag_q[TAG_W-1:2];

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter with NCPU=4: peer read, memory read, write miss,
// round-robin order, invalidate priority and reset abort, all against hand-computed values.
module tb_coherence_bus_arbiter;

  localparam int NCPU    = 4;
  localparam int TAG_W   = 13;
  localparam int WORD_W  = 16;
  localparam int MADDR_W = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCPU-1:0]        rd_miss, wr_miss, inv_req, search_found;
  logic [NCPU*TAG_W-1:0]  req_tag;
  logic [NCPU*WORD_W-1:0] snoop_data;
  logic                   u_rdy;
  logic [NCPU-1:0]        grant, cpu_search, invalidate_out, done;
  logic [TAG_W-1:0]       bus_tag;
  logic [2*NCPU-1:0]      cpu_datasel;
  logic [WORD_W-1:0]      peer_data;
  logic                   u_re;
  logic [MADDR_W-1:0]     u_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coherence_bus_arbiter #(.NCPU(NCPU), .TAG_W(TAG_W), .WORD_W(WORD_W), .MADDR_W(MADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_miss        (rd_miss),
    .wr_miss        (wr_miss),
    .inv_req        (inv_req),
    .req_tag        (req_tag),
    .search_found   (search_found),
    .snoop_data     (snoop_data),
    .u_rdy          (u_rdy),
    .grant          (grant),
    .cpu_search     (cpu_search),
    .bus_tag        (bus_tag),
    .invalidate_out (invalidate_out),
    .cpu_datasel    (cpu_datasel),
    .peer_data      (peer_data),
    .u_re           (u_re),
    .u_addr         (u_addr),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  logic [NCPU-1:0]   rr_oh   [4];
  logic [WORD_W-1:0] rr_data [4];

  initial begin
    rst = 1'b1; rd_miss = '0; wr_miss = '0; inv_req = '0; search_found = '0;
    req_tag = '0; snoop_data = '0; u_rdy = 1'b0;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_u_re", u_re, 0);
    check("rst_done", done, 0);
    check("rst_search", cpu_search, 0);
    check("rst_inv", invalidate_out, 0);
    check("rst_datasel", cpu_datasel, 0);
    check("rst_bus_tag", bus_tag, 0);
    check("rst_peer_data", peer_data, 0);
    check("rst_u_addr", u_addr, 0);

    // Peer read: core 2, core 3 supplies; core 2's own found bit must be masked.
    rst = 1'b0;
    rd_miss = 4'b0100;
    req_tag[2*TAG_W +: TAG_W] = 13'h0104;
    settle();
    check("peer_c0_grant", grant, 0);
    tick();
    rd_miss = '0;
    search_found = 4'b1100;
    snoop_data = {16'hBEEF, 16'h1111, 16'h0000, 16'h0000};
    settle();
    check("peer_c1_grant", grant, 4'b0100);
    check("peer_c1_search", cpu_search, 4'b1011);
    check("peer_c1_bus_tag", bus_tag, 13'h0104);
    tick();
    search_found = '0;
    settle();
    check("peer_c2_grant", grant, 4'b0100);
    check("peer_c2_data", peer_data, 16'hBEEF);
    check("peer_c2_datasel", cpu_datasel, 8'h20);
    check("peer_c2_done", done, 0);
    tick();
    check("peer_c3_done", done, 4'b0100);
    check("peer_c3_grant", grant, 4'b0100);
    check("peer_c3_datasel", cpu_datasel, 0);
    tick();
    check("peer_c4_grant", grant, 0);

    // Memory read: core 0, no snoop hit, u_rdy three cycles after MEM entry.
    rd_miss = 4'b0001;
    req_tag[0 +: TAG_W] = 13'h1FFC;
    tick();
    rd_miss = '0;
    u_rdy = 1'b1;
    settle();
    check("mem_c1_search", cpu_search, 4'b1110);
    check("mem_c1_datasel_ignores_u_rdy", cpu_datasel, 0);
    check("mem_c1_u_re", u_re, 0);
    tick();
    u_rdy = 1'b0;
    settle();
    check("mem_c2_u_addr", u_addr, 11'h7FF);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("mem_c%0d_u_re", i), u_re, 1);
      check($sformatf("mem_c%0d_datasel", i), cpu_datasel, 0);
      tick();
    end
    u_rdy = 1'b1;
    settle();
    check("mem_c5_u_re", u_re, 1);
    check("mem_c5_datasel", cpu_datasel, 8'h01);
    check("mem_c5_done", done, 0);
    tick();
    u_rdy = 1'b0;
    settle();
    check("mem_c6_done", done, 4'b0001);
    check("mem_c6_u_re", u_re, 0);
    tick();
    check("mem_c7_grant", grant, 0);

    // Write miss: core 1; a found bit in SNOOP must not divert it to PEER.
    wr_miss = 4'b0010;
    req_tag[1*TAG_W +: TAG_W] = 13'h0040;
    tick();
    wr_miss = '0;
    search_found = 4'b0001;
    settle();
    check("wr_c1_search", cpu_search, 4'b1101);
    check("wr_c1_inv", invalidate_out, 0);
    check("wr_c1_u_re", u_re, 0);
    tick();
    search_found = '0;
    settle();
    check("wr_c2_inv", invalidate_out, 4'b1101);
    check("wr_c2_u_re", u_re, 0);
    check("wr_c2_datasel", cpu_datasel, 0);
    tick();
    u_rdy = 1'b1;
    settle();
    check("wr_c3_inv", invalidate_out, 0);
    check("wr_c3_u_re", u_re, 1);
    check("wr_c3_datasel", cpu_datasel, 8'h04);
    tick();
    u_rdy = 1'b0;
    settle();
    check("wr_c4_done", done, 4'b0010);
    tick();
    check("wr_c5_grant", grant, 0);

    // Round robin from a fresh pointer: cores 0,1,3 hold rd_miss, cores 1,3 both hit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_miss = 4'b1011;
    search_found = 4'b1010;
    req_tag = '0;
    snoop_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    rr_oh[0] = 4'b0001; rr_data[0] = 16'hA001;
    rr_oh[1] = 4'b0010; rr_data[1] = 16'hA003;
    rr_oh[2] = 4'b1000; rr_data[2] = 16'hA001;
    rr_oh[3] = 4'b0001; rr_data[3] = 16'hA001;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("rr%0d_grant", t), grant, rr_oh[t]);
      tick();
      check($sformatf("rr%0d_peer_data", t), peer_data, rr_data[t]);
      tick();
      check($sformatf("rr%0d_done", t), done, rr_oh[t]);
      tick();
    end
    rd_miss = '0;
    search_found = '0;

    // Core 2 raises inv_req and rd_miss together: invalidate first, read next.
    inv_req = 4'b0100;
    rd_miss = 4'b0100;
    req_tag[2*TAG_W +: TAG_W] = 13'h0200;
    tick();
    check("ir_c1_grant", grant, 4'b0100);
    check("ir_c1_inv", invalidate_out, 4'b1011);
    check("ir_c1_search", cpu_search, 0);
    tick();
    inv_req = '0;
    settle();
    check("ir_c2_done", done, 4'b0100);
    tick();
    check("ir_c3_grant", grant, 0);
    tick();
    rd_miss = '0;
    settle();
    check("ir_c4_grant", grant, 4'b0100);
    check("ir_c4_search", cpu_search, 4'b1011);
    tick();
    check("ir_c5_u_re", u_re, 1);

    // Reset during MEM aborts; a late u_rdy must not complete anything.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_rdy = 1'b1;
    settle();
    check("abort_grant", grant, 0);
    check("abort_u_re", u_re, 0);
    check("abort_bus_tag", bus_tag, 0);
    check("abort_u_addr", u_addr, 0);
    check("abort_datasel", cpu_datasel, 0);
    tick();
    check("abort_late_done", done, 0);
    check("abort_late_grant", grant, 0);
    u_rdy = 1'b0;
    rd_miss = 4'b1001;
    tick();
    check("abort_rr_ptr_zero", grant, 4'b0001);
    rd_miss = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
# coherence_bus_arbiter

Parametrised snooping-bus arbiter and transaction sequencer between NCPU `cpu` instances and unified memory. It generalises the fixed two-core read-miss / write-miss / invalidate handshake to any core count, and adds three things:
- round-robin fairness;
- peer-to-peer line supply with deterministic supplier selection;
- a per-transaction FSM that serialises snoop, invalidate and memory phases.

It sits between every core's cache controller bus ports and the unified memory port.

## Interface
Parameters:
- NCPU, 4: number of cores (2..8).
- TAG_W, 13: width of the bus tag (core word address).
- WORD_W, 16: width of peer-supplied data.
- MADDR_W, 11: width of the unified-memory line address. Must equal TAG_W-2.

Ports (every `[NCPU]`-suffixed port is a packed per-core vector; index i belongs to core i):
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rd_miss  in  NCPU  per-core read-miss request.
- wr_miss  in  NCPU  per-core write-miss request.
- inv_req  in  NCPU  per-core invalidate-others request (write to shared line).
- req_tag  in  NCPU*TAG_W  per-core request tag; slice i is core i.
- search_found  in  NCPU  per-core snoop hit response.
- snoop_data  in  NCPU*WORD_W  per-core data offered on a snoop hit.
- u_rdy  in  1  unified memory operation complete.
- grant  out  NCPU  one-hot; asserted on the winner for the whole transaction.
- cpu_search  out  NCPU  snoop strobe to every core except the winner.
- bus_tag  out  TAG_W  latched winner tag.
- invalidate_out  out  NCPU  invalidate strobe to every core except the winner.
- cpu_datasel  out  2*NCPU  per-core data source.
- peer_data  out  WORD_W  selected supplier data.
- u_re  out  1  unified memory read enable.
- u_addr  out  MADDR_W  unified memory line address = bus_tag[TAG_W-1:2].
- done  out  NCPU  one-cycle completion pulse to the winner.

## Operation
- Request type per core, priority inv_req > wr_miss > rd_miss. Only the highest-priority asserted type is served; the others remain pending.
- Arbitration: round-robin. The search starts at rr_ptr and wraps modulo NCPU. After DONE, rr_ptr = (winner+1) mod NCPU.
- On leaving IDLE, the FSM latches winner index, request type and tag.
- FSM states: IDLE, SNOOP, INV, PEER, MEM, DONE. Transitions:

  IDLE:
  - any request, type inv -> INV.
  - any request, type miss -> SNOOP.
  - no request -> stay in IDLE.

  SNOOP:
  - One cycle. cpu_search = ~winner_onehot.
  - search_found is masked by the same vector and sampled at the end of the cycle.
  - rd_miss with a found bit -> PEER.
  - rd_miss with no found bit -> MEM.
  - wr_miss -> INV.

  INV:
  - One cycle. invalidate_out = ~winner_onehot.
  - Next state: wr_miss -> MEM; inv_req -> DONE.

  PEER:
  - One cycle.
  - Supplier = lowest-index masked found core, as sampled in SNOOP.
  - peer_data = snoop_data slice of the supplier.
  - cpu_datasel[winner] = DS_PEER.
  - Next state -> DONE.

  MEM:
  - u_re held high until u_rdy.
  - In the cycle u_rdy is high: cpu_datasel[winner] = DS_MEM.
  - Next state -> DONE.

  DONE:
  - done[winner] pulses.
  - rr_ptr advances.
  - Next state -> IDLE.
- grant[winner] is high in every non-IDLE state. Outside the winner, and in IDLE, cpu_datasel = DS_NONE.
- Once a request is granted, the transaction is committed. It completes even if the request drops.
- u_rdy is ignored outside MEM.
- A single requester is served back-to-back; there is no starvation penalty.

## Timing
- Reset values: grant, cpu_search, invalidate_out, done, u_re = 0; cpu_datasel = DS_NONE; bus_tag, peer_data, u_addr = 0; rr_ptr = 0; state = IDLE.
- Reset asserted mid-transaction aborts it. All outputs return to their reset values on the next edge.
- Cycle latencies, with the request seen in IDLE at cycle 0 (* = u_rdy cycle):

  | Transaction | Path | Grant cycles | done cycle | Back in IDLE | Next grant at |
  |---|---|---|---|---|---|
  | read, peer supply | SNOOP c1, PEER c2, DONE c3 | 1..3 | 3 | 4 | c5 at the earliest |
  | read, from memory | SNOOP c1, MEM c2.., DONE | from c1 | *+1 | — | — |
  | write miss | SNOOP c1, INV c2, MEM c3.., DONE | from c1 | *+1 | — | — |
  | invalidate | INV c1, DONE c2 | from c1 | 2 | — | — |

- Requests are sampled only in IDLE. Simultaneous arrivals are resolved by rr_ptr in the same cycle.

## Structure
- The shared `common` package holds:
  - `bus_state_t` enum: IDLE, SNOOP, INV, PEER, MEM, DONE.
  - `req_type_t` enum: RT_RD, RT_WR, RT_INV.
  - `datasel_t` constants: DS_NONE = 2'b00, DS_MEM = 2'b01, DS_PEER = 2'b10.
- One sub-module, `rr_picker`. It is parametrised on NCPU and has:
  - inputs: request vector and rr_ptr;
  - outputs: one-hot winner, winner index and a valid flag.
- Lowest-index supplier selection is a small priority encoder, written inline.

## Test plan
- NCPU=4. Core 2 raises rd_miss with tag 0x0104; core 3 answers search_found=1 with snoop_data=0xBEEF.
  - Expected: grant[2] over c1..c3; cpu_search=4'b1011 in c1; peer_data=0xBEEF with cpu_datasel[2]=DS_PEER in c2; done[2] in c3.
- Core 0 raises rd_miss with tag 0x1FFC and no core finds the line; u_rdy arrives 3 cycles after MEM is entered.
  - Expected: u_re high 4 cycles; u_addr=0x7FF; DS_MEM in the u_rdy cycle; done one cycle later.
- Core 1 raises wr_miss.
  - Expected: SNOOP, then invalidate_out=4'b1101 for exactly one cycle, then MEM; u_re asserts only after the INV cycle.
- Cores 0, 1 and 3 all hold rd_miss continuously.
  - Expected: grant order 0, 1, 3, 0. Cores 1 and 3 both found in SNOOP for a core-0 request -> supplier is core 1.
- Core 2 raises inv_req and rd_miss together.
  - Expected: the invalidate is served first (INV/DONE, no SNOOP); the rd_miss is served in the next transaction.
- rst asserted during MEM.
  - Expected: next cycle grant=0, u_re=0, state IDLE, rr_ptr=0; a late u_rdy produces no done.
